// File: rtl/nand_gate_pkg.sv
// rtl/nand_gate_pkg.sv - shared defaults and reset constant for the nand_gate cell
package nand_gate_pkg;

   localparam int NAND_WIDTH = 1;
   localparam int NAND_CNT_W = 16;

   // x_q resets to the NAND of all-zero operands, replicated to WIDTH by the user
   localparam logic NAND_XQ_RST_BIT = 1'b1;

endpackage

// File: rtl/nand_change_monitor.sv
// rtl/nand_change_monitor.sv - registered change pulse and saturating change counter
module nand_change_monitor
   import nand_gate_pkg::*;
#(
   parameter int WIDTH = NAND_WIDTH,
   parameter int CNT_W = NAND_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] next_i,
   output logic             changed_o,
   output logic [CNT_W-1:0] count_o
);

   logic             changed_d, changed_q;
   logic [CNT_W-1:0] count_d, count_q;

   // next_i equals prev_i whenever nothing is loaded, so no separate load qualifier
   always_comb begin
      changed_d = (next_i != prev_i);
      count_d   = count_q;
      if (changed_d && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         changed_q <= 1'b0;
         count_q   <= '0;
      end else begin
         changed_q <= changed_d;
         count_q   <= count_d;
      end
   end

   assign changed_o = changed_q;
   assign count_o   = count_q;

endmodule

// File: rtl/nand_gate.sv
// rtl/nand_gate.sv - bitwise NAND with combinational and valid-qualified registered outputs
module nand_gate
   import nand_gate_pkg::*;
#(
   parameter int WIDTH = NAND_WIDTH,
   parameter int CNT_W = NAND_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] x_q,
   output logic             out_valid,
   output logic             x_changed,
   output logic [CNT_W-1:0] change_count
);

   logic [WIDTH-1:0] res_d, res_q;
   logic             valid_q;

   assign x = ~(a & b);

   always_comb begin
      res_d = res_q;
      if (in_valid) begin
         res_d = x;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= {WIDTH{NAND_XQ_RST_BIT}};
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= in_valid;
      end
   end

   nand_change_monitor #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_monitor (
      .clk       (clk),
      .rst_n     (rst_n),
      .prev_i    (res_q),
      .next_i    (res_d),
      .changed_o (x_changed),
      .count_o   (change_count)
   );

   assign x_q       = res_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_nand_gate.sv
// tb/tb_nand_gate.sv - directed self-checking bench for nand_gate
module tb_nand_gate;

   logic        clk;
   logic        rst_n;

   logic        a0, b0, v0, x0, xq0, ov0, xc0;
   logic [15:0] cnt0;

   logic        a1, b1, v1, x1, xq1, ov1, xc1;
   logic [1:0]  cnt1;

   logic [7:0]  a2, b2, x2, xq2;
   logic        v2, ov2, xc2;
   logic [15:0] cnt2;

   int n_assert = 0;
   int n_fail   = 0;

   nand_gate u_dut0 (
      .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(v0),
      .x(x0), .x_q(xq0), .out_valid(ov0), .x_changed(xc0), .change_count(cnt0)
   );

   nand_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
      .x(x1), .x_q(xq1), .out_valid(ov1), .x_changed(xc1), .change_count(cnt1)
   );

   nand_gate #(.WIDTH(8), .CNT_W(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(v2),
      .x(x2), .x_q(xq2), .out_valid(ov2), .x_changed(xc2), .change_count(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] vec [5];
      logic       exp_xq [5];
      logic       exp_xc [5];
      logic [15:0] exp_cnt [5];

      vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11; vec[4] = 2'b00;
      exp_xq[0] = 1'b1; exp_xq[1] = 1'b1; exp_xq[2] = 1'b1; exp_xq[3] = 1'b0; exp_xq[4] = 1'b1;
      exp_xc[0] = 1'b0; exp_xc[1] = 1'b0; exp_xc[2] = 1'b0; exp_xc[3] = 1'b1; exp_xc[4] = 1'b1;
      exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0; exp_cnt[2] = 16'd0; exp_cnt[3] = 16'd1; exp_cnt[4] = 16'd2;

      a0 = 1'b1; b0 = 1'b1; v0 = 1'b0;
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
      a2 = 8'hF0; b2 = 8'hCC; v2 = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;

      // reset state with a=b=1 driven
      chk("rst_x", x0, 1'b0);
      chk("rst_xq", xq0, 1'b1);
      chk("rst_ov", ov0, 1'b0);
      chk("rst_xc", xc0, 1'b0);
      chk("rst_cnt", cnt0, 16'd0);
      chk("rst_xq_w8", xq2, 8'hFF);
      chk("rst_x_w8", x2, 8'h3F);
      v0 = 1'b1;
      tick();
      chk("rst_hold_xq", xq0, 1'b1);
      chk("rst_hold_ov", ov0, 1'b0);
      v0 = 1'b0;
      rst_n = 1'b1;

      // valid gating: three idle cycles, then one valid load of 1&1
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("gate_xq_%0d", i), xq0, 1'b1);
         chk($sformatf("gate_ov_%0d", i), ov0, 1'b0);
         chk($sformatf("gate_xc_%0d", i), xc0, 1'b0);
      end
      v0 = 1'b1;
      tick();
      chk("gate_load_xq", xq0, 1'b0);
      chk("gate_load_ov", ov0, 1'b1);
      chk("gate_load_xc", xc0, 1'b1);
      chk("gate_load_cnt", cnt0, 16'd1);
      v0 = 1'b0;
      tick();
      chk("gate_after_xq", xq0, 1'b0);
      chk("gate_after_ov", ov0, 1'b0);
      chk("gate_after_xc", xc0, 1'b0);
      chk("gate_after_cnt", cnt0, 16'd1);

      // asynchronous reset mid-cycle, away from any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("async_xq", xq0, 1'b1);
      chk("async_ov", ov0, 1'b0);
      chk("async_cnt", cnt0, 16'd0);
      tick();
      rst_n = 1'b1;

      // truth table and change counting
      v0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a0 = vec[i][1];
         b0 = vec[i][0];
         #1;
         chk($sformatf("tt_x_%0d", i), x0, (vec[i] == 2'b11) ? 1'b0 : 1'b1);
         tick();
         chk($sformatf("tt_xq_%0d", i), xq0, exp_xq[i]);
         chk($sformatf("tt_xc_%0d", i), xc0, exp_xc[i]);
         chk($sformatf("tt_cnt_%0d", i), cnt0, exp_cnt[i]);
      end
      tick();
      chk("reload_equal_xc", xc0, 1'b0);
      chk("reload_equal_cnt", cnt0, 16'd2);
      v0 = 1'b0;

      // saturation with a 2-bit counter
      a1 = 1'b1;
      v1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b1 = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick();
         chk($sformatf("sat_xq_%0d", i), xq1, (i % 2 == 0) ? 1'b0 : 1'b1);
         chk($sformatf("sat_cnt_%0d", i), cnt1, (i < 2) ? i + 1 : 3);
      end
      chk("sat_xc_last", xc1, 1'b1);
      v1 = 1'b0;
      tick();
      chk("sat_hold_cnt", cnt1, 2'd3);

      // 8-bit operands
      chk("w8_x", x2, 8'h3F);
      chk("w8_xq_idle", xq2, 8'hFF);
      v2 = 1'b1;
      tick();
      chk("w8_xq", xq2, 8'h3F);
      chk("w8_ov", ov2, 1'b1);
      chk("w8_xc", xc2, 1'b1);
      chk("w8_cnt", cnt2, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
